muldiv_unit: RTL

Iterative RV64M multiply/divide unit for the multicycle core. It sits directly downstream of the A/B operand registers and takes the same 64-bit operands the ALU sees. Its result feeds the register-file write-data mux as an extra source, and `busy` holds the control state machine in its execute state. One bit per cycle: shift-add for multiply, restoring division for divide.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_WORD_OPS_EN enables the 32-bit W-variant datapath.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            word_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [5:0]        r_count;
    logic              r_load;
    logic              r_negRes;
    logic              r_negRem;
    logic              r_special;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_magB;
    logic [XLEN-1:0]   r_specVal;
    logic [2*XLEN-1:0] r_prod;
`ifdef MULDIV_WORD_OPS_EN
    logic              r_word;
    logic              w_word;
`else
    logic              w_unused;
    assign w_unused = word_op;
`endif

    logic              w_signA, w_signB, w_negA, w_negB;
    logic              w_divZero, w_ovf, w_special;
    logic [XLEN-1:0]   w_aExt, w_bExt, w_minVal, w_magA, w_magB;
    logic [XLEN-1:0]   w_remDiv0, w_specVal;
    logic [5:0]        w_countInit;
    logic [2*XLEN-1:0] w_prodInit;

    // Operand conditioning at acceptance: extension, magnitudes, signs, special cases.
    always_comb begin
        w_signA     = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
        w_signB     = w_signA && (funct3 != 3'd2);
        w_aExt      = op_a;
        w_bExt      = op_b;
        w_minVal    = MIN_VAL;
        w_countInit = 6'(XLEN - 1);
`ifdef MULDIV_WORD_OPS_EN
        w_word = word_op && ((funct3 == 3'd0) || funct3[2]);
        if (w_word) begin
            w_aExt      = w_signA ? {{32{op_a[31]}}, op_a[31:0]} : {32'b0, op_a[31:0]};
            w_bExt      = w_signB ? {{32{op_b[31]}}, op_b[31:0]} : {32'b0, op_b[31:0]};
            w_minVal    = {{33{1'b1}}, 31'b0};
            w_countInit = 6'd31;
        end
`endif
        w_negA    = w_signA && w_aExt[XLEN-1];
        w_negB    = w_signB && w_bExt[XLEN-1];
        w_magA    = w_negA ? -w_aExt : w_aExt;
        w_magB    = w_negB ? -w_bExt : w_bExt;
        w_divZero = (w_bExt == '0);
        w_ovf     = w_signA && (w_aExt == w_minVal) && (w_bExt == '1);
        w_special = funct3[2] && (w_divZero || w_ovf);
        w_remDiv0 = w_aExt;
`ifdef MULDIV_WORD_OPS_EN
        if (w_word) w_remDiv0 = {{32{w_aExt[31]}}, w_aExt[31:0]};
`endif
        if (w_divZero) w_specVal = funct3[1] ? w_remDiv0 : '1;
        else           w_specVal = funct3[1] ? '0 : w_aExt;
        w_prodInit = {{XLEN{1'b0}}, w_magA};
`ifdef MULDIV_WORD_OPS_EN
        // A 32-step divide must see the dividend at the top of the quotient half.
        if (w_word && funct3[2]) w_prodInit = {{XLEN{1'b0}}, w_magA[31:0], 32'b0};
`endif
    end

    logic [XLEN:0]     w_sum, w_shRem;
    logic              w_fits;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_mulNext, w_divNext;

    always_comb begin
        w_sum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_magB};
        w_mulNext = r_prod[0] ? {w_sum, r_prod[XLEN-1:1]} : {1'b0, r_prod[2*XLEN-1:1]};
        w_shRem   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
        w_fits    = (w_shRem >= {1'b0, r_magB});
        w_diff    = w_shRem[XLEN-1:0] - r_magB;
        w_divNext = w_fits ? {w_diff, r_prod[XLEN-2:0], 1'b1}
                           : {w_shRem[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] w_prodFix;
    logic [XLEN-1:0]   w_quo, w_rem, w_divSel, w_final;

    // Sign fix-up and half/width selection for the SIGN state.
    always_comb begin
        w_prodFix = r_negRes ? -r_prod : r_prod;
        w_quo     = r_negRes ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
        w_rem     = r_negRem ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];
        w_divSel  = r_funct3[1] ? w_rem : w_quo;
        if (r_funct3[2])            w_final = w_divSel;
        else if (r_funct3 == 3'd0) w_final = w_prodFix[XLEN-1:0];
        else                        w_final = w_prodFix[2*XLEN-1:XLEN];
`ifdef MULDIV_WORD_OPS_EN
        if (r_word) begin
            w_final = r_funct3[2] ? {{32{w_divSel[31]}}, w_divSel[31:0]}
                                  : {{32{w_prodFix[63]}}, w_prodFix[63:32]};
        end
`endif
    end

    // The first CALC cycle only resolves special cases; iterations start after it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_load    <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_special <= 1'b0;
            r_funct3  <= '0;
            r_magB    <= '0;
            r_specVal <= '0;
            r_prod    <= '0;
`ifdef MULDIV_WORD_OPS_EN
            r_word    <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_funct3  <= funct3;
                        r_magB    <= w_magB;
                        r_prod    <= w_prodInit;
                        r_negRes  <= w_negA ^ w_negB;
                        r_negRem  <= w_negA;
                        r_special <= w_special;
                        r_specVal <= w_specVal;
                        r_count   <= w_countInit;
`ifdef MULDIV_WORD_OPS_EN
                        r_word    <= w_word;
`endif
                        r_load    <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= CALC;
                    end
                end
                CALC: begin
                    if (r_load) begin
                        r_load <= 1'b0;
                        if (r_special) begin
                            result  <= r_specVal;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_prod  <= r_funct3[2] ? w_divNext : w_mulNext;
                        r_count <= r_count - 6'd1;
                        if (r_count == 6'd0) r_state <= SIGN;
                    end
                end
                SIGN: begin
                    result  <= w_final;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
